cm162_cascade_counter: RTL and testbench
========================================

Name: cm162_cascade_counter

Overview:
- Sequential counterpart of the CM162 next-state slice: holds the counter state that the slice's combinational logic updates, and cascades NIBBLES 4-bit slices into one synchronous counter.
- Each nibble uses the CM162 count/load/enable rules: synchronous load, dual count enables, and ripple carry into the next nibble.
- Adds a registered terminal-count pulse and a saturating wrap counter, which downstream logic consumes.

Parameters:
- NIBBLES, 4, number of cascaded 4-bit slices; counter width W = 4*NIBBLES (range 1..8).
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  master slice enable. When low, state holds and load/count are ignored.
- load  input  1  synchronous parallel load. Has priority over counting.
- cnt_p  input  1  count enable P; gates state update only.
- cnt_t  input  1  count enable T; gates update and the carry chain.
- load_data  input  W  value loaded when load is active.
- count  output  W  registered counter state.
- carry_out  output  1  combinational: cnt_t & (count == all ones).
- tc_pulse  output  1  registered one-cycle pulse when the counter wraps from all ones to 0.
- wrap_count  output  WRAP_W  registered count of wraps; saturates at all ones.

Behaviour:
- Reset (async, active-high): count=0, tc_pulse=0, wrap_count=0, applied immediately. Deassertion is synchronous to clock. Reset mid-operation discards any pending load or count.
- Per-edge priority: reset > (enable==0: hold all state, tc_pulse=0) > load > count > hold.
- Load (enable & load):
  - count <= load_data next edge; cnt_p and cnt_t are ignored.
  - tc_pulse=0; wrap_count is unchanged, even when load_data is all ones.
- Count (enable & ~load & cnt_p & cnt_t): count <= count + 1 mod 2^W. Implemented as a nibble ripple:
  - nibble k increments iff cnt_t and all lower nibbles == 4'hF (nibble 0 uses cnt_t alone).
  - Each nibble carry = its carry-in & (nibble == 4'hF).
- Hold: count unchanged if cnt_p or cnt_t is low.
- Wrap: a count step from all ones to 0 sets tc_pulse=1 for exactly one cycle (next cycle) and wrap_count += 1 unless already all ones (saturate, no rollover). Any non-wrap cycle drives tc_pulse=0.
- carry_out:
  - purely combinational from registered count and live cnt_t, with no enable, load or cnt_p gating. This matches CM162 ripple-carry semantics and allows external cascading.
  - Asserted during the cycle before a wrap when counting.
- Load and wrap cannot coincide, because load has priority.
- enable low freezes count, so carry_out still reflects count and cnt_t.
- Latency: every state change appears one clock after the qualifying inputs. There are no multi-cycle paths.
- Inputs are assumed synchronous to clock; no internal synchronizers.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with count=16'h1234 -> count=0, tc_pulse=0, wrap_count=0 immediately; after release with cnt_p=cnt_t=enable=1, count=1 after first edge.
- Load: load=1, load_data=16'hFFFE, cnt_p=cnt_t=1 -> count=16'hFFFE next edge, no tc_pulse. Two further counts -> 16'hFFFF with carry_out=1, then 16'h0000 with tc_pulse=1 one cycle, wrap_count=1.
- Nibble ripple: load 16'h00FF and count once -> 16'h0100. Load 16'h0FFF and count -> 16'h1000. Hold cnt_p=0 with cnt_t=1 at 16'hFFFF -> count holds, carry_out=1, no tc_pulse.
- Enable/hold: enable=0 with load=1, load_data=16'hAAAA -> count unchanged. cnt_t=0 at 16'hFFFF -> carry_out=0, no change.
- Saturation: WRAP_W=2, force 5 wraps via load 16'hFFFF plus one count each -> wrap_count 1,2,3,3,3; tc_pulse on all 5 wraps.
- Parameter sweep: NIBBLES=1 counting from 4'hE -> 4'hF (carry_out=1) -> 4'h0 (tc_pulse); NIBBLES=8 load 32'hFFFFFFFF then count -> 0, tc_pulse=1.

Source files
------------

// File: rtl/cm162_cascade_counter_if.sv
// Bundles the control inputs and status outputs of the cascaded CM162 counter.
// The counter width follows NIBBLES, so the interface and the counter must use the same parameters.
interface cm162_cascade_counter_if #(
  parameter int NIBBLES = 4,
  parameter int WRAP_W  = 8
);
  localparam int W = 4 * NIBBLES;

  logic              enable;
  logic              load;
  logic              cnt_p;
  logic              cnt_t;
  logic [W-1:0]      load_data;
  logic [W-1:0]      count;
  logic              carry_out;
  logic              tc_pulse;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output enable, load, cnt_p, cnt_t, load_data,
    input  count, carry_out, tc_pulse, wrap_count
  );

  modport slave (
    input  enable, load, cnt_p, cnt_t, load_data,
    output count, carry_out, tc_pulse, wrap_count
  );
endinterface

// File: rtl/cm162_cascade_counter.sv
// Synchronous counter built from NIBBLES cascaded CM162 slices. It adds a registered
// terminal-count pulse and a saturating count of wraps.
module cm162_cascade_counter #(
  parameter int NIBBLES = 4,
  parameter int WRAP_W  = 8
) (
  input logic                    clock,
  input logic                    reset,
  cm162_cascade_counter_if.slave bus
);
  localparam int W = 4 * NIBBLES;

  logic [W-1:0]      count_r;
  logic [W-1:0]      count_next_s;
  logic [NIBBLES:0]  carry_s;
  logic              tc_pulse_r;
  logic [WRAP_W-1:0] wrap_count_r;
  logic              wrap_full_s;

  // Nibble ripple: each slice steps only when cnt_t reaches it through a chain of 4'hF nibbles
  always_comb begin
    carry_s      = '0;
    count_next_s = count_r;
    carry_s[0]   = bus.cnt_t;
    for (int k = 0; k < NIBBLES; k++) begin
      if (carry_s[k]) begin
        count_next_s[4*k +: 4] = count_r[4*k +: 4] + 4'd1;
      end else begin
        count_next_s[4*k +: 4] = count_r[4*k +: 4];
      end
      carry_s[k+1] = carry_s[k] & (count_r[4*k +: 4] == 4'hF);
    end
  end

  assign wrap_full_s = &wrap_count_r;

  // Counter state, wrap pulse and saturating wrap count, in reset > enable > load > count priority
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r      <= '0;
      tc_pulse_r   <= 1'b0;
      wrap_count_r <= '0;
    end else if (!bus.enable) begin
      tc_pulse_r <= 1'b0;
    end else if (bus.load) begin
      count_r    <= bus.load_data;
      tc_pulse_r <= 1'b0;
    end else if (bus.cnt_p && bus.cnt_t) begin
      count_r    <= count_next_s;
      // The top carry is high exactly when the whole counter is all ones, so this step wraps
      tc_pulse_r <= carry_s[NIBBLES];
      if (carry_s[NIBBLES] && !wrap_full_s) begin
        wrap_count_r <= wrap_count_r + WRAP_W'(1);
      end else begin
        wrap_count_r <= wrap_count_r;
      end
    end else begin
      tc_pulse_r <= 1'b0;
    end
  end

  assign bus.count      = count_r;
  assign bus.carry_out  = carry_s[NIBBLES];
  assign bus.tc_pulse   = tc_pulse_r;
  assign bus.wrap_count = wrap_count_r;
endmodule

// File: tb/tb_cm162_cascade_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream, and each is
// compared against an arithmetic reference model after every edge and every async reset.
module tb_cm162_cascade_counter;
  logic        clock;
  logic        reset;
  logic        enable;
  logic        load;
  logic        cnt_p;
  logic        cnt_t;
  logic [31:0] ld32;

  int compared   = 0;
  int mismatched = 0;

  // The four configurations: main 16-bit, 2-bit wrap counter, 1 nibble, 8 nibbles
  cm162_cascade_counter_if #(.NIBBLES(4), .WRAP_W(8)) if_main ();
  cm162_cascade_counter_if #(.NIBBLES(4), .WRAP_W(2)) if_sat ();
  cm162_cascade_counter_if #(.NIBBLES(1), .WRAP_W(8)) if_n1 ();
  cm162_cascade_counter_if #(.NIBBLES(8), .WRAP_W(8)) if_n8 ();

  cm162_cascade_counter #(.NIBBLES(4), .WRAP_W(8)) dut_main (.clock(clock), .reset(reset), .bus(if_main));
  cm162_cascade_counter #(.NIBBLES(4), .WRAP_W(2)) dut_sat  (.clock(clock), .reset(reset), .bus(if_sat));
  cm162_cascade_counter #(.NIBBLES(1), .WRAP_W(8)) dut_n1   (.clock(clock), .reset(reset), .bus(if_n1));
  cm162_cascade_counter #(.NIBBLES(8), .WRAP_W(8)) dut_n8   (.clock(clock), .reset(reset), .bus(if_n8));

  assign if_main.enable = enable;  assign if_main.load = load;
  assign if_main.cnt_p  = cnt_p;   assign if_main.cnt_t = cnt_t;
  assign if_main.load_data = ld32[15:0];
  assign if_sat.enable  = enable;  assign if_sat.load  = load;
  assign if_sat.cnt_p   = cnt_p;   assign if_sat.cnt_t  = cnt_t;
  assign if_sat.load_data  = ld32[15:0];
  assign if_n1.enable   = enable;  assign if_n1.load   = load;
  assign if_n1.cnt_p    = cnt_p;   assign if_n1.cnt_t   = cnt_t;
  assign if_n1.load_data   = ld32[3:0];
  assign if_n8.enable   = enable;  assign if_n8.load   = load;
  assign if_n8.cnt_p    = cnt_p;   assign if_n8.cnt_t   = cnt_t;
  assign if_n8.load_data   = ld32;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: plain modular arithmetic on each configuration's width
  int    wbits [4] = '{16, 16, 4, 32};
  longint wmax [4] = '{255, 3, 255, 255};
  string  names[4] = '{"main", "sat", "n1", "n8"};
  longint m_cnt [4];
  longint m_wrap[4];
  longint m_tc  [4];

  function automatic longint mask_of(int i);
    return (64'd1 << wbits[i]) - 64'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 0; m_tc[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      if (!enable) begin
        m_tc[i] = 0;
      end else if (load) begin
        m_cnt[i] = longint'(ld32) & mask_of(i);
        m_tc[i]  = 0;
      end else if (cnt_p && cnt_t) begin
        if (m_cnt[i] == mask_of(i)) begin
          m_cnt[i] = 0;
          m_tc[i]  = 1;
          if (m_wrap[i] < wmax[i]) m_wrap[i] = m_wrap[i] + 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
          m_tc[i]  = 0;
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic check(string tag, longint obs, longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint oc[4], ot[4], ow[4], oco[4];
    oc[0] = longint'(if_main.count); ot[0] = longint'(if_main.tc_pulse);
    ow[0] = longint'(if_main.wrap_count); oco[0] = longint'(if_main.carry_out);
    oc[1] = longint'(if_sat.count);  ot[1] = longint'(if_sat.tc_pulse);
    ow[1] = longint'(if_sat.wrap_count);  oco[1] = longint'(if_sat.carry_out);
    oc[2] = longint'(if_n1.count);   ot[2] = longint'(if_n1.tc_pulse);
    ow[2] = longint'(if_n1.wrap_count);   oco[2] = longint'(if_n1.carry_out);
    oc[3] = longint'(if_n8.count);   ot[3] = longint'(if_n8.tc_pulse);
    ow[3] = longint'(if_n8.wrap_count);   oco[3] = longint'(if_n8.carry_out);
    for (int i = 0; i < 4; i++) begin
      check({names[i], ".count"}, oc[i], m_cnt[i]);
      check({names[i], ".tc_pulse"}, ot[i], m_tc[i]);
      check({names[i], ".wrap_count"}, ow[i], m_wrap[i]);
      check({names[i], ".carry_out"}, oco[i],
            (cnt_t && m_cnt[i] == mask_of(i)) ? 64'd1 : 64'd0);
    end
  endtask

  task automatic set_in(bit en, bit ld, bit p, bit t, logic [31:0] d);
    enable = en; load = ld; cnt_p = p; cnt_t = t; ld32 = d;
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Called at posedge+1: raises reset mid-cycle, checks the immediate effect, releases before the next edge
  task automatic pulse_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    #3;
    reset = 1'b0;

    // Async reset mid-operation, then count from zero
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
    step();
    check("dir.load1234", longint'(if_main.count), 64'h1234);
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5555);
    pulse_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    check("dir.first_count", longint'(if_main.count), 64'h1);

    // Load near the top, count to all ones, then wrap
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_FFFE);
    step();
    check("dir.load_tc", longint'(if_main.tc_pulse), 64'd0);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step();
    check("dir.carry_ffff", longint'(if_main.carry_out), 64'd1);
    step();
    check("dir.wrap_count", longint'(if_main.count), 64'h0);
    check("dir.wrap_tc", longint'(if_main.tc_pulse), 64'd1);
    check("dir.wrap_cnt", longint'(if_main.wrap_count), 64'd1);
    step();
    check("dir.tc_one_cycle", longint'(if_main.tc_pulse), 64'd0);

    // Nibble ripple boundaries
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00FF); step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);         step();
    check("dir.ripple_0100", longint'(if_main.count), 64'h0100);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0FFF); step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);         step();
    check("dir.ripple_1000", longint'(if_main.count), 64'h1000);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF); step();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);         step();
    step();
    check("dir.hold_p0", longint'(if_main.count), 64'hFFFF);
    check("dir.hold_p0_carry", longint'(if_main.carry_out), 64'd1);

    // Enable low ignores load; cnt_t low kills carry_out
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_AAAA); step();
    check("dir.enable_low", longint'(if_main.count), 64'hFFFF);
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);         step();
    check("dir.t0_carry", longint'(if_main.carry_out), 64'd0);

    // Saturation of the 2-bit wrap counter over five wraps
    pulse_reset();
    for (int j = 0; j < 5; j++) begin
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF); step();
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);         step();
      check("dir.sat_tc", longint'(if_sat.tc_pulse), 64'd1);
      check("dir.sat_wrap", longint'(if_sat.wrap_count), (j < 3) ? longint'(j + 1) : 64'd3);
      check("dir.n8_wrap", longint'(if_n8.count), 64'h0);
    end

    // Single-nibble counting from E through F to 0
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE); step();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);         step();
    check("dir.n1_carry", longint'(if_n1.carry_out), 64'd1);
    step();
    check("dir.n1_tc", longint'(if_n1.tc_pulse), 64'd1);

    // Randomized traffic, biased toward loads near all ones so wraps occur
    for (int n = 0; n < 400; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'hFFFF_FFFF;
        1:       d = 32'hFFFF_FFFE;
        2:       d = 32'hFFFF_FF0F;
        default: d = $urandom;
      endcase
      set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0), d);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
